// File: rtl/id_issue.sv
// id_issue: RV64 decode/issue stage. Decodes a fetched instruction and reads
// the register file. It builds the ALU operands and writeback metadata into a
// single ID/EX register, and stalls RAW hazards against a 32-entry busy
// scoreboard until the producer writes back.
module id_issue #(
  parameter int XLEN      = 64,
  parameter bit RESET_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [14:0]     ex_op_ir,
  output logic [XLEN-1:0] ex_sdata,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_illegal
);

  localparam logic [14:0] NOP_IR = RESET_NOP ? 15'h0013 : 15'h0000;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_OPIMMW = 7'h1B;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_AMO    = 7'h2F;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OPW    = 7'h3B;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] pc;
    logic [14:0]     op_ir;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } idex_t;

  localparam idex_t IDEX_RST = '{a: '0, b: '0, sdata: '0, pc: '0,
                                 op_ir: NOP_IR, rd: '0, we: 1'b0, ill: 1'b0};

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, uimm;
  logic            use1, use2, haz1, haz2, hazard, accept;
  idex_t           dec, idex;
  logic            vld;
  logic [31:0]     busy, busy_nxt;

  assign opc    = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_u = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'h000};
  assign uimm  = {{(XLEN-5){1'b0}}, if_instr[19:15]};

  // Decode: operand muxing, write enable and source-usage flags per opcode.
  // An opcode list match implies instr[1:0]==2'b11, so the default arm also
  // catches compressed/invalid encodings.
  always_comb begin
    dec       = '0;
    dec.pc    = if_pc;
    dec.sdata = rf_rd2;
    dec.rd    = rd;
    dec.op_ir = {if_instr[31:27], if_instr[14:12], if_instr[6:0]};
    use1      = 1'b1;
    use2      = 1'b0;
    unique case (opc)
      OPC_OP, OPC_OPW, OPC_AMO: begin
        dec.a = rf_rd1; dec.b = rf_rd2; dec.we = 1'b1; use2 = 1'b1;
      end
      OPC_OPIMM, OPC_OPIMMW, OPC_LOAD, OPC_JALR: begin
        dec.a = rf_rd1; dec.b = imm_i; dec.we = 1'b1;
      end
      OPC_STORE: begin
        dec.a = rf_rd1; dec.b = imm_s; use2 = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a = rf_rd1; dec.b = rf_rd2; use2 = 1'b1;
      end
      OPC_LUI: begin
        dec.b = imm_u; dec.we = 1'b1; use1 = 1'b0;
      end
      OPC_AUIPC: begin
        dec.a = if_pc; dec.b = imm_u; dec.we = 1'b1; use1 = 1'b0;
      end
      OPC_JAL: begin
        dec.a = if_pc; dec.b = XLEN'(4); dec.we = 1'b1; use1 = 1'b0;
      end
      OPC_SYSTEM: begin
        dec.a = rf_rd1; dec.b = uimm; dec.we = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    if (rd == 5'd0) dec.we = 1'b0;
  end

  // RAW detection against the scoreboard and the instruction sitting in ID/EX
  // (not yet in the scoreboard until it is consumed).
  always_comb begin
    haz1     = use1 && (rs1 != 5'd0) &&
               (busy[rs1] || (vld && idex.we && idex.rd == rs1));
    haz2     = use2 && (rs2 != 5'd0) &&
               (busy[rs2] || (vld && idex.we && idex.rd == rs2));
    hazard   = haz1 || haz2;
    if_ready = !rst && !flush && !hazard && (!vld || ex_ready);
    accept   = if_valid && if_ready;
  end

  // ID/EX register: load on accept, drop valid when drained, hold on stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld  <= 1'b0;
      idex <= IDEX_RST;
    end else if (accept) begin
      vld  <= 1'b1;
      idex <= dec;
    end else if (ex_ready) begin
      vld  <= 1'b0;
    end
  end

  // Scoreboard next state: writeback clear first so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid && wb_rd != 5'd0) busy_nxt[wb_rd] = 1'b0;
    if (vld && ex_ready && idex.we) busy_nxt[idex.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign ex_valid   = vld;
  assign ex_a       = idex.a;
  assign ex_b       = idex.b;
  assign ex_op_ir   = idex.op_ir;
  assign ex_sdata   = idex.sdata;
  assign ex_pc      = idex.pc;
  assign ex_rd      = idex.rd;
  assign ex_we      = idex.we;
  assign ex_illegal = idex.ill;

endmodule
